// File: rtl/ingress_rdreq_dispatch.sv
// ingress_rdreq_dispatch: decodes read-request offsets into a {flag, register, action, channel}
// destination and queues each request with its completion context in a fall-through FIFO.
// Revision: 1.0
`default_nettype none

module ingress_rdreq_dispatch #(
  parameter int CHANNEL_NUM = 12,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdreq_valid,
  output logic             rdreq_rdy,
  input  logic [3:0]       rdreq_chnl,
  input  logic [3:0]       rdreq_offset,
  input  logic [7:0]       rdreq_tag,
  input  logic [15:0]      rdreq_reqid,
  input  logic [6:0]       rdreq_laddr,
  output logic             rd_valid,
  input  logic             rd_rdy,
  output logic [9:0]       rd_tdest,
  output logic [7:0]       rd_tag,
  output logic [15:0]      rd_reqid,
  output logic [6:0]       rd_laddr,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 41;
  localparam logic [AW:0] FULL_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0]  CH_LIM_C = 5'(CHANNEL_NUM);

  logic [1:0]  w_act;
  logic [2:0]  w_reg;
  logic        w_per_chnl;
  logic        w_known;
  logic        w_unsup;
  logic [9:0]  w_tdest;
  logic        w_push;
  logic        w_pop;
  logic [EW-1:0] w_head;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    w_act      = 2'b11;
    w_reg      = 3'b000;
    w_per_chnl = 1'b0;
    w_known    = 1'b1;
    case (rdreq_offset)
      4'b1000: begin w_act = 2'b00; w_reg = 3'b000; w_per_chnl = 1'b1; end
      4'b1001: begin w_act = 2'b00; w_reg = 3'b001; w_per_chnl = 1'b1; end
      4'b1110: begin w_act = 2'b00; w_reg = 3'b010; w_per_chnl = 1'b1; end
      4'b1101: begin w_act = 2'b01; w_reg = 3'b010; w_per_chnl = 1'b1; end
      4'b1010: begin w_act = 2'b10; w_reg = 3'b000; end
      4'b1011: begin w_act = 2'b10; w_reg = 3'b001; end
      4'b1100: begin w_act = 2'b10; w_reg = 3'b010; end
      4'b1111: begin w_act = 2'b10; w_reg = 3'b011; end
      default: w_known = 1'b0;
    endcase
    // Global registers ignore the channel; only tx/rx registers need a real channel.
    w_unsup = !w_known || (w_per_chnl && ({1'b0, rdreq_chnl} >= CH_LIM_C));
    w_tdest = w_unsup ? {1'b1, 3'b000, 2'b11, rdreq_chnl}
                      : {1'b0, w_reg, w_act, rdreq_chnl};
  end

  assign rdreq_rdy = (count_q != FULL_C);
  assign rd_valid  = (count_q != '0);
  assign w_push    = rdreq_valid && rdreq_rdy;
  assign w_pop     = rd_valid && rd_rdy;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    acc_cnt_d = acc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (w_push && (acc_cnt_q != '1))            acc_cnt_d = acc_cnt_q + CNT_W'(1);
    if (w_push && w_unsup && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      acc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      acc_cnt_q <= acc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem[wr_ptr_q] <= {w_tdest, rdreq_tag, rdreq_reqid, rdreq_laddr};
  end

  // Storage is not reset, so the head is masked to zero while the queue is empty.
  assign w_head   = rd_valid ? mem[rd_ptr_q] : '0;
  assign rd_tdest = w_head[40:31];
  assign rd_tag   = w_head[30:23];
  assign rd_reqid = w_head[22:7];
  assign rd_laddr = w_head[6:0];
  assign acc_cnt  = acc_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ingress_rdreq_dispatch.sv
// Bench for ingress_rdreq_dispatch: two configurations driven in parallel, each checked
// against a queue-based reference model.
`default_nettype none

module tb_ingress_rdreq_dispatch;

  logic        clk;
  logic        rst;
  logic        rdreq_valid;
  logic [3:0]  rdreq_chnl;
  logic [3:0]  rdreq_offset;
  logic [7:0]  rdreq_tag;
  logic [15:0] rdreq_reqid;
  logic [6:0]  rdreq_laddr;
  logic        rd_rdy;

  logic        a_rdreq_rdy, a_rd_valid;
  logic [9:0]  a_rd_tdest;
  logic [7:0]  a_rd_tag;
  logic [15:0] a_rd_reqid;
  logic [6:0]  a_rd_laddr;
  logic [15:0] a_acc_cnt, a_err_cnt;

  logic        b_rdreq_rdy, b_rd_valid;
  logic [9:0]  b_rd_tdest;
  logic [7:0]  b_rd_tag;
  logic [15:0] b_rd_reqid;
  logic [6:0]  b_rd_laddr;
  logic [3:0]  b_acc_cnt, b_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ingress_rdreq_dispatch dut_a (
    .clk(clk), .rst(rst), .rdreq_valid(rdreq_valid), .rdreq_rdy(a_rdreq_rdy),
    .rdreq_chnl(rdreq_chnl), .rdreq_offset(rdreq_offset), .rdreq_tag(rdreq_tag),
    .rdreq_reqid(rdreq_reqid), .rdreq_laddr(rdreq_laddr), .rd_valid(a_rd_valid),
    .rd_rdy(rd_rdy), .rd_tdest(a_rd_tdest), .rd_tag(a_rd_tag), .rd_reqid(a_rd_reqid),
    .rd_laddr(a_rd_laddr), .acc_cnt(a_acc_cnt), .err_cnt(a_err_cnt)
  );

  ingress_rdreq_dispatch #(.CHANNEL_NUM(4), .FIFO_DEPTH(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .rdreq_valid(rdreq_valid), .rdreq_rdy(b_rdreq_rdy),
    .rdreq_chnl(rdreq_chnl), .rdreq_offset(rdreq_offset), .rdreq_tag(rdreq_tag),
    .rdreq_reqid(rdreq_reqid), .rdreq_laddr(rdreq_laddr), .rd_valid(b_rd_valid),
    .rd_rdy(rd_rdy), .rd_tdest(b_rd_tdest), .rd_tag(b_rd_tag), .rd_reqid(b_rd_reqid),
    .rd_laddr(b_rd_laddr), .acc_cnt(b_acc_cnt), .err_cnt(b_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: one queue of {tdest, tag, reqid, laddr} per configuration.
  logic [40:0] qa[$];
  logic [40:0] qb[$];
  int  acc_a, err_a, acc_b, err_b;
  bit  pristine_a, pristine_b;
  bit  armed = 1'b0;

  task automatic check(input string tg, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tg, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] exp_dest(input logic [3:0] ch, input logic [3:0] off,
                                          input int chn);
    logic [1:0] act;
    logic [2:0] rg;
    bit per;
    bit ok;
    act = 2'b11; rg = 3'b000; per = 1'b0; ok = 1'b1;
    case (off)
      4'b1000: begin act = 2'b00; rg = 3'd0; per = 1'b1; end
      4'b1001: begin act = 2'b00; rg = 3'd1; per = 1'b1; end
      4'b1110: begin act = 2'b00; rg = 3'd2; per = 1'b1; end
      4'b1101: begin act = 2'b01; rg = 3'd2; per = 1'b1; end
      4'b1010: begin act = 2'b10; rg = 3'd0; end
      4'b1011: begin act = 2'b10; rg = 3'd1; end
      4'b1100: begin act = 2'b10; rg = 3'd2; end
      4'b1111: begin act = 2'b10; rg = 3'd3; end
      default: ok = 1'b0;
    endcase
    if (per && int'(ch) >= chn) ok = 1'b0;
    return ok ? {1'b0, rg, act, ch} : {1'b1, 3'b000, 2'b11, ch};
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [3:0] ch,
                       input logic [3:0] off, input logic [7:0] tg, input logic [15:0] rid,
                       input logic [6:0] la, input logic rr);
    logic [9:0] d;
    bit push_a, pop_a, push_b, pop_b;
    @(negedge clk);
    if (armed) begin
      check("a_valid", 64'(a_rd_valid), 64'(qa.size() != 0));
      check("a_rdy", 64'(a_rdreq_rdy), 64'(qa.size() != 8));
      if (qa.size() != 0)
        check("a_head", 64'({a_rd_tdest, a_rd_tag, a_rd_reqid, a_rd_laddr}), 64'(qa[0]));
      else if (pristine_a)
        check("a_empty_zero", 64'({a_rd_tdest, a_rd_tag, a_rd_reqid, a_rd_laddr}), 64'(0));
      check("a_acc", 64'(a_acc_cnt), 64'(acc_a));
      check("a_err", 64'(a_err_cnt), 64'(err_a));
      check("b_valid", 64'(b_rd_valid), 64'(qb.size() != 0));
      check("b_rdy", 64'(b_rdreq_rdy), 64'(qb.size() != 8));
      if (qb.size() != 0)
        check("b_head", 64'({b_rd_tdest, b_rd_tag, b_rd_reqid, b_rd_laddr}), 64'(qb[0]));
      else if (pristine_b)
        check("b_empty_zero", 64'({b_rd_tdest, b_rd_tag, b_rd_reqid, b_rd_laddr}), 64'(0));
      check("b_acc", 64'(b_acc_cnt), 64'(acc_b));
      check("b_err", 64'(b_err_cnt), 64'(err_b));
    end
    rst = r; rdreq_valid = v; rdreq_chnl = ch; rdreq_offset = off;
    rdreq_tag = tg; rdreq_reqid = rid; rdreq_laddr = la; rd_rdy = rr;
    if (r) begin
      qa.delete(); qb.delete();
      acc_a = 0; err_a = 0; acc_b = 0; err_b = 0;
      pristine_a = 1'b1; pristine_b = 1'b1;
      armed = 1'b1;
    end else if (armed) begin
      push_a = v && (qa.size() != 8);
      pop_a  = rr && (qa.size() != 0);
      push_b = v && (qb.size() != 8);
      pop_b  = rr && (qb.size() != 0);
      if (pop_a) void'(qa.pop_front());
      if (pop_b) void'(qb.pop_front());
      if (push_a) begin
        d = exp_dest(ch, off, 12);
        qa.push_back({d, tg, rid, la});
        if (acc_a < 65535) acc_a++;
        if (d[9] && err_a < 65535) err_a++;
        pristine_a = 1'b0;
      end
      if (push_b) begin
        d = exp_dest(ch, off, 4);
        qb.push_back({d, tg, rid, la});
        if (acc_b < 15) acc_b++;
        if (d[9] && err_b < 15) err_b++;
        pristine_b = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 4'd0, 8'd0, 16'd0, 7'd0, rr);
  endtask

  logic [3:0] offs [8];

  initial begin
    rst = 1'b1; rdreq_valid = 1'b0; rdreq_chnl = '0; rdreq_offset = '0;
    rdreq_tag = '0; rdreq_reqid = '0; rdreq_laddr = '0; rd_rdy = 1'b0;
    offs = '{4'b1000, 4'b1001, 4'b1110, 4'b1101, 4'b1010, 4'b1011, 4'b1100, 4'b1111};

    // Reset, then a single tx request.
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 8'd0, 16'd0, 7'd0, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 8'd0, 16'd0, 7'd0, 1'b0);
    cycle(1'b0, 1'b1, 4'd3, 4'b1000, 8'h15, 16'h0100, 7'h20, 1'b1);
    idle(3, 1'b1);

    // Every supported offset, back-to-back.
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b1, 4'd5, offs[i], 8'(i), 16'(i * 3), 7'(i), 1'b1);
    idle(3, 1'b1);

    // Out-of-range channel on an rx register vs. a global register.
    cycle(1'b0, 1'b1, 4'd7, 4'b1101, 8'hA1, 16'h1234, 7'h11, 1'b1);
    cycle(1'b0, 1'b1, 4'd7, 4'b1010, 8'hA2, 16'h1235, 7'h12, 1'b1);
    idle(3, 1'b1);

    // Write-only offset between two valid requests.
    cycle(1'b0, 1'b1, 4'd1, 4'b1001, 8'hB0, 16'h0001, 7'h01, 1'b0);
    cycle(1'b0, 1'b1, 4'd1, 4'b0100, 8'hB1, 16'h0002, 7'h02, 1'b0);
    cycle(1'b0, 1'b1, 4'd1, 4'b1011, 8'hB2, 16'h0003, 7'h03, 1'b0);
    idle(5, 1'b1);

    // Fill with the consumer stalled, hold two extra requests, then drain.
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b1, 4'(i), offs[i], 8'(8'hC0 + i), 16'(i), 7'(i), 1'b0);
    cycle(1'b0, 1'b1, 4'd2, 4'b1110, 8'hC8, 16'hCCC8, 7'h48, 1'b0);
    cycle(1'b0, 1'b1, 4'd2, 4'b1110, 8'hC8, 16'hCCC8, 7'h48, 1'b0);
    cycle(1'b0, 1'b1, 4'd2, 4'b1110, 8'hC8, 16'hCCC8, 7'h48, 1'b1);
    cycle(1'b0, 1'b1, 4'd2, 4'b1110, 8'hC8, 16'hCCC8, 7'h48, 1'b1);
    cycle(1'b0, 1'b1, 4'd9, 4'b0001, 8'hC9, 16'hCCC9, 7'h49, 1'b1);
    idle(12, 1'b1);

    // Full queue, then reset during an active handshake.
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b1, 4'd0, 4'b1111, 8'(i), 16'(i), 7'(i), 1'b0);
    cycle(1'b1, 1'b1, 4'd0, 4'b1000, 8'hEE, 16'hEEEE, 7'h6E, 1'b1);
    idle(3, 1'b1);

    // Saturate the narrow counters.
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 1'b1, 4'd6, 4'b0010, 8'(i), 16'(i), 7'(i), 1'b1);
    idle(2, 1'b1);

    // Randomized traffic with occasional resets and bursty backpressure.
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            4'($urandom), 4'($urandom), 8'($urandom), 16'($urandom), 7'($urandom),
            ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    idle(12, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
